// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences direct and indirect loads and stores onto a
// simple request/acknowledge memory port.
// Optional build macro MEM_ACCESS_TIMEOUT_EN adds a wait counter that aborts
// an access with err=1 after TIMEOUT_CYC unacknowledged request cycles.
// Without the macro the block waits for Data_ack indefinitely and err is 0.
module mem_access_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mem_op,
    input  logic [ADDR_W-1:0] M_Addr,
    input  logic [DATA_W-1:0] M_Data,
    input  logic [DATA_W-1:0] Data_dout,
    input  logic              Data_ack,
    output logic [ADDR_W-1:0] Data_addr,
    output logic [DATA_W-1:0] Data_din,
    output logic              Data_rd,
    output logic              Data_req,
    output logic [DATA_W-1:0] memout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IND_RD  = 3'd1,
        DATA_RD = 3'd2,
        DATA_WR = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_STI = 2'b11;

    state_t            state;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] data_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0]  wait_cnt;
    logic              err_q;
`endif

    // Pointer fetched from memory becomes an address: truncate or zero-extend.
    function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] d);
        logic [ADDR_W-1:0] a;
        a = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (i < DATA_W) a[i] = d[i];
        end
        return a;
    endfunction

    // Main sequencer: state, registered memory-port outputs and status.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= OP_LD;
            data_q    <= '0;
            Data_addr <= '0;
            Data_din  <= '0;
            Data_rd   <= 1'b1;
            Data_req  <= 1'b0;
            memout    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= mem_op;
                        data_q    <= M_Data;
                        Data_addr <= M_Addr;
                        Data_req  <= 1'b1;
                        busy      <= 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        if (mem_op == OP_LD) begin
                            Data_rd <= 1'b1;
                            state   <= DATA_RD;
                        end else if (mem_op == OP_ST) begin
                            Data_rd  <= 1'b0;
                            Data_din <= M_Data;
                            state    <= DATA_WR;
                        end else begin
                            Data_rd <= 1'b1;
                            state   <= IND_RD;
                        end
                    end
                end
                IND_RD: begin
                    // Request drops for one cycle while the pointer becomes the address.
                    if (Data_ack) begin
                        Data_addr <= to_addr(Data_dout);
                        Data_req  <= 1'b0;
                        state     <= (op_q == OP_STI) ? DATA_WR : DATA_RD;
                    end
                end
                DATA_RD: begin
                    if (!Data_req) begin
                        Data_req <= 1'b1;
                        Data_rd  <= 1'b1;
                    end else if (Data_ack) begin
                        memout   <= Data_dout;
                        Data_req <= 1'b0;
                        state    <= DONE;
                    end
                end
                DATA_WR: begin
                    if (!Data_req) begin
                        Data_req <= 1'b1;
                        Data_rd  <= 1'b0;
                        Data_din <= data_q;
                    end else if (Data_ack) begin
                        Data_req <= 1'b0;
                        Data_rd  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Data_req <= 1'b0;
                    Data_rd  <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
`ifdef MEM_ACCESS_TIMEOUT_EN
            // Count unacknowledged request cycles; the abort overrides the case above.
            if (Data_req && !Data_ack) begin
                if (wait_cnt == CNT_LAST) begin
                    wait_cnt <= '0;
                    Data_req <= 1'b0;
                    Data_rd  <= 1'b1;
                    err_q    <= 1'b1;
                    state    <= DONE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
`endif
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: load, store, LDI, STI, ignored start
// and stray ack, reset mid-access, and wait/timeout behaviour.
module tb_mem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  mem_op;
    logic [15:0] M_Addr;
    logic [15:0] M_Data;
    logic [15:0] Data_dout;
    logic        Data_ack;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic        Data_rd;
    logic        Data_req;
    logic [15:0] memout;
    logic        busy;
    logic        done;
    logic        err;

    int compared;
    int mismatched;

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYC(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mem_op    (mem_op),
        .M_Addr    (M_Addr),
        .M_Data    (M_Data),
        .Data_dout (Data_dout),
        .Data_ack  (Data_ack),
        .Data_addr (Data_addr),
        .Data_din  (Data_din),
        .Data_rd   (Data_rd),
        .Data_req  (Data_req),
        .memout    (memout),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Small memory image answering whatever address is presented.
    always_comb begin
        case (Data_addr)
            16'h3000: Data_dout = 16'h1234;
            16'h3010: Data_dout = 16'h5000;
            16'h5000: Data_dout = 16'h00AA;
            16'h3020: Data_dout = 16'h6000;
            default:  Data_dout = 16'h0000;
        endcase
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset();
        chk("rst_addr", {16'h0, Data_addr}, 32'h0);
        chk("rst_din",  {16'h0, Data_din},  32'h0);
        chk("rst_rd",   {31'h0, Data_rd},   32'h1);
        chk("rst_req",  {31'h0, Data_req},  32'h0);
        chk("rst_mem",  {16'h0, memout},    32'h0);
        chk("rst_busy", {31'h0, busy},      32'h0);
        chk("rst_done", {31'h0, done},      32'h0);
        chk("rst_err",  {31'h0, err},       32'h0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset    = 1'b0;
        start    = 1'b0;
        mem_op   = 2'b00;
        M_Addr   = 16'h0;
        M_Data   = 16'h0;
        Data_ack = 1'b0;

        // Reset state
        step();
        step();
        chk_idle_reset();
        reset = 1'b1;
        step();
        chk("idle_req", {31'h0, Data_req}, 32'h0);

        // Load 0x3000 with two wait cycles
        start = 1'b1; mem_op = 2'b00; M_Addr = 16'h3000;
        step();
        start = 1'b0;
        chk("ld_req",  {31'h0, Data_req}, 32'h1);
        chk("ld_addr", {16'h0, Data_addr}, 32'h3000);
        chk("ld_rd",   {31'h0, Data_rd}, 32'h1);
        chk("ld_busy", {31'h0, busy}, 32'h1);
        step();
        chk("ld_wait1", {31'h0, Data_req}, 32'h1);
        step();
        chk("ld_wait2", {31'h0, Data_req}, 32'h1);
        Data_ack = 1'b1;
        step();
        Data_ack = 1'b0;
        chk("ld_req_drop", {31'h0, Data_req}, 32'h0);
        chk("ld_memout", {16'h0, memout}, 32'h1234);
        chk("ld_done_early", {31'h0, done}, 32'h0);
        step();
        chk("ld_done", {31'h0, done}, 32'h1);
        chk("ld_err", {31'h0, err}, 32'h0);
        chk("ld_busy_end", {31'h0, busy}, 32'h0);
        step();
        chk("ld_done_once", {31'h0, done}, 32'h0);

        // Store 0x4000 <- 0xBEEF with ack tied high
        Data_ack = 1'b1;
        start = 1'b1; mem_op = 2'b01; M_Addr = 16'h4000; M_Data = 16'hBEEF;
        step();
        start = 1'b0;
        chk("st_req",  {31'h0, Data_req}, 32'h1);
        chk("st_rd",   {31'h0, Data_rd}, 32'h0);
        chk("st_addr", {16'h0, Data_addr}, 32'h4000);
        chk("st_din",  {16'h0, Data_din}, 32'hBEEF);
        step();
        chk("st_req_drop", {31'h0, Data_req}, 32'h0);
        chk("st_rd_back", {31'h0, Data_rd}, 32'h1);
        chk("st_done_early", {31'h0, done}, 32'h0);
        step();
        chk("st_done", {31'h0, done}, 32'h1);
        chk("st_memout", {16'h0, memout}, 32'h1234);

        // LDI via 0x3010 -> 0x5000 -> 0x00AA, ack tied high
        start = 1'b1; mem_op = 2'b10; M_Addr = 16'h3010;
        step();
        start = 1'b0;
        chk("ldi_ptr_addr", {16'h0, Data_addr}, 32'h3010);
        chk("ldi_ptr_req", {31'h0, Data_req}, 32'h1);
        chk("ldi_ptr_rd", {31'h0, Data_rd}, 32'h1);
        step();
        chk("ldi_gap_req", {31'h0, Data_req}, 32'h0);
        step();
        chk("ldi_dat_req", {31'h0, Data_req}, 32'h1);
        chk("ldi_dat_addr", {16'h0, Data_addr}, 32'h5000);
        chk("ldi_dat_rd", {31'h0, Data_rd}, 32'h1);
        step();
        chk("ldi_memout", {16'h0, memout}, 32'h00AA);
        chk("ldi_done_early", {31'h0, done}, 32'h0);
        step();
        chk("ldi_done", {31'h0, done}, 32'h1);

        // STI via 0x3020 -> write 0x0F0F to 0x6000
        start = 1'b1; mem_op = 2'b11; M_Addr = 16'h3020; M_Data = 16'h0F0F;
        step();
        start = 1'b0;
        chk("sti_ptr_addr", {16'h0, Data_addr}, 32'h3020);
        chk("sti_ptr_rd", {31'h0, Data_rd}, 32'h1);
        step();
        chk("sti_gap_req", {31'h0, Data_req}, 32'h0);
        step();
        chk("sti_wr_req", {31'h0, Data_req}, 32'h1);
        chk("sti_wr_rd", {31'h0, Data_rd}, 32'h0);
        chk("sti_wr_addr", {16'h0, Data_addr}, 32'h6000);
        chk("sti_wr_din", {16'h0, Data_din}, 32'h0F0F);
        step();
        chk("sti_req_drop", {31'h0, Data_req}, 32'h0);
        chk("sti_memout", {16'h0, memout}, 32'h00AA);
        step();
        chk("sti_done", {31'h0, done}, 32'h1);
        Data_ack = 1'b0;

        // Start while busy and stray ack are ignored
        start = 1'b1; mem_op = 2'b00; M_Addr = 16'h5000;
        step();
        mem_op = 2'b01; M_Addr = 16'h1111; M_Data = 16'hFFFF;
        step();
        start = 1'b0;
        chk("busy_addr", {16'h0, Data_addr}, 32'h5000);
        chk("busy_rd", {31'h0, Data_rd}, 32'h1);
        chk("busy_req", {31'h0, Data_req}, 32'h1);
        Data_ack = 1'b1;
        step();
        chk("busy_memout", {16'h0, memout}, 32'h00AA);
        chk("busy_req_drop", {31'h0, Data_req}, 32'h0);
        step();
        chk("busy_done", {31'h0, done}, 32'h1);
        step();
        chk("stray_done", {31'h0, done}, 32'h0);
        chk("stray_req", {31'h0, Data_req}, 32'h0);
        chk("stray_busy", {31'h0, busy}, 32'h0);
        step();
        chk("stray_done2", {31'h0, done}, 32'h0);
        chk("stray_din", {16'h0, Data_din}, 32'h0F0F);
        Data_ack = 1'b0;

        // Reset mid-access
        start = 1'b1; mem_op = 2'b01; M_Addr = 16'h7000; M_Data = 16'h1357;
        step();
        start = 1'b0;
        chk("mid_req", {31'h0, Data_req}, 32'h1);
        reset = 1'b0;
        step();
        chk_idle_reset();
        reset = 1'b1;
        step();
        chk("post_rst_done", {31'h0, done}, 32'h0);
        chk("post_rst_req", {31'h0, Data_req}, 32'h0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Timeout after 15 unacknowledged cycles
        start = 1'b1; mem_op = 2'b00; M_Addr = 16'h3000;
        step();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("to_wait_req", {31'h0, Data_req}, 32'h1);
        end
        step();
        chk("to_req_drop", {31'h0, Data_req}, 32'h0);
        chk("to_err", {31'h0, err}, 32'h1);
        step();
        chk("to_done", {31'h0, done}, 32'h1);
        chk("to_done_err", {31'h0, err}, 32'h1);
        chk("to_memout", {16'h0, memout}, 32'h0);
        start = 1'b1; mem_op = 2'b00; M_Addr = 16'h3000;
        step();
        start = 1'b0;
        chk("to_err_clr", {31'h0, err}, 32'h0);
        Data_ack = 1'b1;
        step();
        step();
        chk("to_recover_done", {31'h0, done}, 32'h1);
        chk("to_recover_mem", {16'h0, memout}, 32'h1234);
        Data_ack = 1'b0;
`else
        // Without timeout the request is held as long as ack stays low
        start = 1'b1; mem_op = 2'b00; M_Addr = 16'h3000;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("nto_req_held", {31'h0, Data_req}, 32'h1);
        chk("nto_err", {31'h0, err}, 32'h0);
        Data_ack = 1'b1;
        step();
        Data_ack = 1'b0;
        chk("nto_memout", {16'h0, memout}, 32'h1234);
        step();
        chk("nto_done", {31'h0, done}, 32'h1);
        chk("nto_done_err", {31'h0, err}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
